// File: rtl/biquad_coeff_smoother.sv
// biquad_coeff_smoother
//
// Coefficient stage in front of `biquad`. It holds target values for a0, a1,
// a2, b1 and b2 and moves the live coefficients toward them with a one-pole
// step once per audio frame, so filter setting changes do not cause zipper
// noise.
//
// Per frame:
//   - On the bclk edge that sees lrclk rise while IDLE, all five live outputs
//     take the shadow (next) values together. `settled` is updated on the
//     same edge.
//   - During the following 5 cycles (UPD) one shadow value per cycle moves a
//     step toward its target, in the order a0, a1, a2, b1, b2.
//
// Ports:
//   bclk        only clock, rising edge
//   rst         asynchronous active-high reset
//   lrclk       frame clock, sampled on bclk
//   load_valid  target load request
//   load_ready  high while IDLE (combinational)
//   load_snap   qualifies a load: shadow jumps straight to the targets
//   t_a0..t_b2  signed target coefficients
//   a0..b2      signed live coefficients, wired to `biquad`
//   settled     high when every live coefficient equals its target

module biquad_coeff_smoother #(
    parameter int BITSIZE    = 16,
    parameter int STEP_SHIFT = 4
) (
    input  logic               bclk,
    input  logic               rst,
    input  logic               lrclk,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic               load_snap,
    input  logic [BITSIZE-1:0] t_a0,
    input  logic [BITSIZE-1:0] t_a1,
    input  logic [BITSIZE-1:0] t_a2,
    input  logic [BITSIZE-1:0] t_b1,
    input  logic [BITSIZE-1:0] t_b2,
    output logic [BITSIZE-1:0] a0,
    output logic [BITSIZE-1:0] a1,
    output logic [BITSIZE-1:0] a2,
    output logic [BITSIZE-1:0] b1,
    output logic [BITSIZE-1:0] b2,
    output logic               settled
);

    typedef enum logic {
        IDLE = 1'b0,
        UPD  = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd4;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic               lrclk_q, lrclk_d;
    logic               settled_q, settled_d;
    logic [BITSIZE-1:0] tgt_q [5];
    logic [BITSIZE-1:0] tgt_d [5];
    logic [BITSIZE-1:0] shd_q [5];
    logic [BITSIZE-1:0] shd_d [5];
    logic [BITSIZE-1:0] out_q [5];
    logic [BITSIZE-1:0] out_d [5];
    logic [BITSIZE-1:0] t_in  [5];
    logic               rise_s;
    logic               all_eq_s;

    // One glide step. The difference needs one extra bit so that full-scale
    // moves (e.g. 32767 -> -32768) do not wrap. When the shifted step
    // vanishes but a difference remains, a +/-1 nudge guarantees the value
    // still reaches its target exactly. |step| <= |diff| so the sum cannot
    // overshoot and always fits back in BITSIZE bits.
    function automatic logic [BITSIZE-1:0] glide(input logic [BITSIZE-1:0] cur,
                                                 input logic [BITSIZE-1:0] tgt);
        logic signed [BITSIZE:0] diff;
        logic signed [BITSIZE:0] shifted;
        logic signed [BITSIZE:0] nudge;
        logic signed [BITSIZE:0] step;
        diff    = $signed({tgt[BITSIZE-1], tgt}) - $signed({cur[BITSIZE-1], cur});
        shifted = diff >>> STEP_SHIFT;
        nudge   = diff[BITSIZE] ? {(BITSIZE+1){1'b1}} : {{BITSIZE{1'b0}}, 1'b1};
        step    = ((shifted == '0) && (diff != '0)) ? nudge : shifted;
        glide   = cur + step[BITSIZE-1:0];
    endfunction

    assign t_in[0] = t_a0;
    assign t_in[1] = t_a1;
    assign t_in[2] = t_a2;
    assign t_in[3] = t_b1;
    assign t_in[4] = t_b2;

    assign a0      = out_q[0];
    assign a1      = out_q[1];
    assign a2      = out_q[2];
    assign b1      = out_q[3];
    assign b2      = out_q[4];
    assign settled = settled_q;

    assign load_ready = (state_q == IDLE);
    assign rise_s     = lrclk & ~lrclk_q;

    // Shadow-equals-target check used when a commit samples `settled`.
    always_comb begin
        all_eq_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (shd_q[i] != tgt_q[i]) begin
                all_eq_s = 1'b0;
            end else begin
                all_eq_s = all_eq_s;
            end
        end
    end

    // Next-state logic: commit on frame rise, shadow update pass, target load.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lrclk_d   = lrclk;
        settled_d = settled_q;
        for (int i = 0; i < 5; i++) begin
            tgt_d[i] = tgt_q[i];
            shd_d[i] = shd_q[i];
            out_d[i] = out_q[i];
        end

        case (state_q)
            IDLE: begin
                // Commit uses the shadow as it stands before this edge, even
                // if a snap load is landing on the same edge.
                if (rise_s) begin
                    for (int i = 0; i < 5; i++) begin
                        out_d[i] = shd_q[i];
                    end
                    settled_d = all_eq_s;
                    state_d   = UPD;
                    idx_d     = 3'd0;
                end else begin
                    state_d   = IDLE;
                end
                if (load_valid) begin
                    for (int i = 0; i < 5; i++) begin
                        tgt_d[i] = t_in[i];
                        shd_d[i] = load_snap ? t_in[i] : shd_q[i];
                    end
                end else begin
                    idx_d = idx_d;
                end
            end
            UPD: begin
                for (int i = 0; i < 5; i++) begin
                    if (idx_q == 3'(i)) begin
                        shd_d[i] = glide(shd_q[i], tgt_q[i]);
                    end else begin
                        shd_d[i] = shd_q[i];
                    end
                end
                if (idx_q >= LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                end else begin
                    idx_d   = idx_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 3'd0;
            lrclk_q   <= 1'b0;
            settled_q <= 1'b1;
            for (int i = 0; i < 5; i++) begin
                tgt_q[i] <= '0;
                shd_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lrclk_q   <= lrclk_d;
            settled_q <= settled_d;
            for (int i = 0; i < 5; i++) begin
                tgt_q[i] <= tgt_d[i];
                shd_q[i] <= shd_d[i];
                out_q[i] <= out_d[i];
            end
        end
    end

endmodule

// File: tb/tb_biquad_coeff_smoother.sv
// Self-checking bench for biquad_coeff_smoother: a table of directed
// load/frame vectors, hand-written sequences for the multi-cycle corners,
// and randomized traffic checked against a frame-level reference model.

module tb_biquad_coeff_smoother;

    localparam int SH = 4;

    logic               bclk;
    logic               rst;
    logic               lrclk;
    logic               load_valid;
    logic               load_ready;
    logic               load_snap;
    logic               settled;
    logic signed [15:0] t_in  [5];
    logic signed [15:0] c_out [5];

    int n_vec;
    int n_err;

    // Reference model state (frame-level: a whole shadow pass is applied at
    // the commit, since nothing can load or commit while the pass runs).
    int m_tgt [5];
    int m_shd [5];
    int m_out [5];
    bit m_set;
    bit m_lr_prev;
    int m_busy;
    int m_loads;

    biquad_coeff_smoother #(.BITSIZE(16), .STEP_SHIFT(SH)) dut (
        .bclk       (bclk),
        .rst        (rst),
        .lrclk      (lrclk),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_snap  (load_snap),
        .t_a0       (t_in[0]),
        .t_a1       (t_in[1]),
        .t_a2       (t_in[2]),
        .t_b1       (t_in[3]),
        .t_b2       (t_in[4]),
        .a0         (c_out[0]),
        .a1         (c_out[1]),
        .a2         (c_out[2]),
        .b1         (c_out[3]),
        .b2         (c_out[4]),
        .settled    (settled)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit              snap;
        logic [4:0][15:0] t;
        logic [4:0][15:0] e;
        bit              es;
    } vec_t;

    function automatic vec_t mk(bit snap, int t0, int t1, int t2, int t3, int t4,
                                int e0, int e1, int e2, int e3, int e4, bit es);
        vec_t v;
        v.snap = snap;
        v.t    = {16'(t4), 16'(t3), 16'(t2), 16'(t1), 16'(t0)};
        v.e    = {16'(e4), 16'(e3), 16'(e2), 16'(e1), 16'(e0)};
        v.es   = es;
        return v;
    endfunction

    function automatic int glide(int s, int t);
        int d;
        int st;
        d  = t - s;
        st = d >>> SH;
        if (st == 0 && d != 0) st = (d > 0) ? 1 : -1;
        return s + st;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            m_tgt[i] = 0;
            m_shd[i] = 0;
            m_out[i] = 0;
        end
        m_set     = 1'b1;
        m_lr_prev = 1'b0;
        m_busy    = 0;
    endtask

    task automatic model_update();
        bit rise;
        bit all_eq;
        if (rst) begin
            model_reset();
            return;
        end
        rise      = lrclk && !m_lr_prev;
        m_lr_prev = lrclk;
        if (m_busy > 0) begin
            m_busy--;
        end else begin
            if (rise) begin
                all_eq = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    m_out[i] = m_shd[i];
                    if (m_shd[i] != m_tgt[i]) all_eq = 1'b0;
                end
                m_set = all_eq;
            end
            if (load_valid) begin
                m_loads++;
                for (int i = 0; i < 5; i++) begin
                    m_tgt[i] = int'(t_in[i]);
                    if (load_snap) m_shd[i] = int'(t_in[i]);
                end
            end
            if (rise) begin
                for (int i = 0; i < 5; i++) m_shd[i] = glide(m_shd[i], m_tgt[i]);
                m_busy = 5;
            end
        end
    endtask

    task automatic tick();
        @(posedge bclk);
        model_update();
        @(negedge bclk);
    endtask

    task automatic check_model(string tag);
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s_c%0d", tag, i), int'(c_out[i]), m_out[i]);
        chk({tag, "_settled"}, int'(settled), int'(m_set));
        chk({tag, "_ready"}, int'(load_ready), int'(m_busy == 0));
    endtask

    // One frame: lrclk high for the first half, low for the rest.
    task automatic frame(int len, bit rnd, string tag);
        lrclk = 1'b1;
        for (int c = 0; c < len; c++) begin
            if (c == len / 2) lrclk = 1'b0;
            if (rnd) begin
                load_valid = ($urandom_range(0, 3) == 0);
                load_snap  = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < 5; i++)
                    t_in[i] = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                         : 16'($urandom_range(0, 40)) - 16'sd20;
            end
            tick();
            check_model(tag);
        end
        load_valid = 1'b0;
        load_snap  = 1'b0;
    endtask

    task automatic do_load(bit snap);
        load_valid = 1'b1;
        load_snap  = snap;
        tick();
        load_valid = 1'b0;
        load_snap  = 1'b0;
        check_model("load");
    endtask

    vec_t tbl [13];

    initial begin
        int prev;
        int lows;
        int xfers;
        int base;
        bit done;

        n_vec = 0;
        n_err = 0;
        m_loads = 0;
        rst = 1'b1;
        lrclk = 1'b0;
        load_valid = 1'b0;
        load_snap = 1'b0;
        for (int i = 0; i < 5; i++) t_in[i] = 16'sd0;
        model_reset();

        tbl[0]  = mk(0, 16384, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 16384, 0, 0, 0, 0,     1024, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 16384, 0, 0, 0, 0,     1984, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 16384, 0, 0, 0, 0,     2884, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 8192, -4096, 2048, -12000, 5000,  8192, -4096, 2048, -12000, 5000, 1);
        tbl[5]  = mk(1, 8192, -4096, 2048, 100, 5000,     8192, -4096, 2048, 100, 5000, 1);
        tbl[6]  = mk(0, 8192, -4096, 2048, 95, 5000,      8192, -4096, 2048, 100, 5000, 0);
        tbl[7]  = mk(0, 8192, -4096, 2048, 95, 5000,      8192, -4096, 2048, 99, 5000, 0);
        tbl[8]  = mk(0, 8192, -4096, 2048, 95, 5000,      8192, -4096, 2048, 98, 5000, 0);
        tbl[9]  = mk(0, 8192, -4096, 2048, 95, 5000,      8192, -4096, 2048, 97, 5000, 0);
        tbl[10] = mk(0, 8192, -4096, 2048, 95, 5000,      8192, -4096, 2048, 96, 5000, 0);
        tbl[11] = mk(0, 8192, -4096, 2048, 95, 5000,      8192, -4096, 2048, 95, 5000, 1);
        tbl[12] = mk(0, 8192, -4096, 2048, 95, 5000,      8192, -4096, 2048, 95, 5000, 1);

        // Reset state, with no clock edge required.
        #1;
        for (int i = 0; i < 5; i++) chk($sformatf("reset_c%0d", i), int'(c_out[i]), 0);
        chk("reset_settled", int'(settled), 1);
        chk("reset_ready", int'(load_ready), 1);
        @(negedge bclk);
        @(negedge bclk);
        rst = 1'b0;
        tick();
        tick();
        check_model("idle");

        // Directed table: load, one frame, compare with hand-derived values.
        for (int k = 0; k < 13; k++) begin
            for (int i = 0; i < 5; i++) t_in[i] = $signed(tbl[k].t[i]);
            do_load(tbl[k].snap);
            frame(16, 0, "tblf");
            for (int i = 0; i < 5; i++)
                chk($sformatf("tbl%0d_c%0d", k, i), int'(c_out[i]), int'($signed(tbl[k].e[i])));
            chk($sformatf("tbl%0d_settled", k), int'(settled), int'(tbl[k].es));
        end

        // Full-scale descent on b2: monotonic, no wrap, settles exactly.
        t_in[4] = 16'sd32767;
        do_load(1'b1);
        frame(8, 0, "b2snap");
        chk("b2_start", int'(c_out[4]), 32767);
        t_in[4] = -16'sd32768;
        do_load(1'b0);
        prev = 32767;
        done = 1'b0;
        for (int f = 0; f < 300 && !done; f++) begin
            frame(8, 0, "b2f");
            chk("b2_mono", int'(int'(c_out[4]) <= prev), 1);
            prev = int'(c_out[4]);
            if (settled && c_out[4] == -16'sd32768) done = 1'b1;
        end
        chk("b2_final", int'(c_out[4]), -32768);
        chk("b2_settled", int'(settled), 1);

        // Handshake: load_valid held through two frames.
        base  = m_loads;
        xfers = 0;
        load_valid = 1'b1;
        for (int f = 0; f < 2; f++) begin
            lows  = 0;
            lrclk = 1'b1;
            for (int c = 0; c < 12; c++) begin
                if (c == 6) lrclk = 1'b0;
                for (int i = 0; i < 5; i++) t_in[i] = 16'($urandom);
                if (load_ready) xfers++;
                tick();
                check_model("hs");
                if (!load_ready) lows++;
            end
            chk("hs_low_cycles", lows, 5);
        end
        load_valid = 1'b0;
        chk("hs_transfers", xfers, m_loads - base);
        frame(16, 0, "hs_after");
        frame(16, 0, "hs_after");

        // Short frame: a rise 3 cycles after a commit is ignored.
        t_in[0] = 16'sd1000;  t_in[1] = -16'sd1000; t_in[2] = 16'sd500;
        t_in[3] = -16'sd500;  t_in[4] = 16'sd30000;
        do_load(1'b1);
        t_in[0] = 16'sd2000;  t_in[1] = 16'sd0; t_in[2] = 16'sd0;
        t_in[3] = 16'sd0;     t_in[4] = -16'sd30000;
        do_load(1'b0);
        lrclk = 1'b1; tick(); check_model("sf_commit");
        lrclk = 1'b0; tick(); check_model("sf_upd");
        tick(); check_model("sf_upd");
        lrclk = 1'b1; tick(); check_model("sf_rise");
        tick(); tick(); tick(); check_model("sf_hold");
        chk("sf_a0_held", int'(c_out[0]), 1000);
        chk("sf_b2_held", int'(c_out[4]), 30000);
        chk("sf_settled", int'(settled), 0);
        lrclk = 1'b0;
        for (int c = 0; c < 4; c++) begin tick(); check_model("sf_low"); end
        frame(16, 0, "sf_next");
        chk("sf_a0_next", int'(c_out[0]), 1062);

        // Randomized frames against the model.
        for (int f = 0; f < 150; f++) frame(int'($urandom_range(6, 20)), 1, "rnd");

        // Asynchronous reset in the middle of a shadow pass.
        t_in[0] = 16'sd4000; t_in[3] = -16'sd7000;
        do_load(1'b1);
        frame(16, 0, "pre_rst");
        lrclk = 1'b1; tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 5; i++) chk($sformatf("arst_c%0d", i), int'(c_out[i]), 0);
        chk("arst_settled", int'(settled), 1);
        chk("arst_ready", int'(load_ready), 1);
        lrclk = 1'b0;
        @(negedge bclk);
        rst = 1'b0;
        frame(16, 0, "post_rst");
        chk("post_rst_a0", int'(c_out[0]), 0);
        chk("post_rst_settled", int'(settled), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/biquad_coeff_smoother.md
# biquad_coeff_smoother

Upstream coefficient stage for `biquad`. Holds target values for a0, a1, a2, b1 and b2, and glides the live coefficients toward them with a one-pole step once per audio frame, which avoids zipper noise when filter settings change. All five outputs change together on the `bclk` edge that detects the `lrclk` rising edge. That is the half-frame in which `biquad` holds its sequencer at step 0, so coefficients are stable for its whole computation. Targets are loaded through a valid/ready handshake from the control/register side.

## Interface

Parameters:
- `BITSIZE`, 16, coefficient width (signed, same format as `biquad`).
- `STEP_SHIFT`, 4, smoothing shift; per-frame step = (target − current) >>> STEP_SHIFT.

Ports:
- `bclk` in 1: the only clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `lrclk` in 1: frame clock, sampled synchronously on `bclk`.
- `load_valid` in 1: target load request.
- `load_ready` out 1: high when a load can be accepted.
- `load_snap` in 1: qualifies a load; jump straight to targets with no glide.
- `t_a0`, `t_a1`, `t_a2`, `t_b1`, `t_b2` in BITSIZE each: signed target coefficients.
- `a0`, `a1`, `a2`, `b1`, `b2` out BITSIZE each: signed live coefficients, wired to `biquad`.
- `settled` out 1: high when every live coefficient equals its target.

## Operation

- **Internal state:** five target registers, five shadow registers (next coefficient values), `lrclk_q` (previous `lrclk`), 3-bit index `idx`, state machine IDLE/UPD.
- **Frame edge:** rise = `lrclk` & ~`lrclk_q`.
- **IDLE + rise (commit):**
  - outputs ← shadow.
  - `settled` ← (shadow == target for all five).
  - state ← UPD, `idx` ← 0.
- **UPD:** one coefficient per cycle, order a0, a1, a2, b1, b2 (`idx` 0..4).
  - shadow[idx] ← shadow[idx] + step(target[idx] − shadow[idx]).
  - After `idx` = 4, state ← IDLE.
- **Step arithmetic:**
  - diff is computed at BITSIZE+1 bits signed.
  - step = diff >>> STEP_SHIFT (arithmetic shift).
  - If step = 0 and diff ≠ 0, step = +1 or −1 by the sign of diff.
  - Because |step| ≤ |diff|, the result never overshoots and always stays within BITSIZE range. No saturation logic is required.
- **Load handshake:**
  - `load_ready` = (state == IDLE), combinational.
  - Transfer happens when `load_valid` & `load_ready` on a clock edge: targets ← t_*.
  - If `load_snap` is also set, shadow ← t_* as well.
  - Live outputs never change on a load; the new values appear at the next commit.
- **Boundary cases:**
  - Rise during UPD: ignored, no commit. The shadow pass finishes normally and the next rise commits.
  - Load and rise on the same edge in IDLE: both take effect. The commit uses the old shadow; the UPD pass uses the new targets.
  - Target equal to shadow: step 0 and the shadow is unchanged.
  - Reset mid-UPD: everything returns to reset values immediately; no partial state is kept.
- **Reset values:**
  - a0, a1, a2, b1, b2 = 0; targets = 0; shadow = 0.
  - `settled` = 1; `lrclk_q` = 0; state = IDLE; `idx` = 0.
  - Therefore `load_ready` = 1.

## Timing

- **Commit latency:** outputs update on the first `bclk` edge where `lrclk` is sampled high with `lrclk_q` low. They hold until the next commit.
- **UPD occupancy:** exactly 5 cycles after commit. `load_ready` is low for those 5 cycles and high otherwise.
- **Minimum frame:** 6 `bclk` per `lrclk` period for a commit every frame. Standard I2S frames of 64 `bclk` satisfy this.
- **Glide latency:**
  - Non-snap load: the first moved value appears at the 2nd commit after the load. The 1st commit still presents the old shadow.
  - Snap load: targets appear at the 1st commit after the load.
- **`settled`** changes only at commits.

## Test plan

- **Reset:** assert `rst` asynchronously mid-UPD → all coefficients 0, `settled` = 1, `load_ready` = 1 with no clock edge needed; after release the first commit keeps 0.
- **Glide:** `STEP_SHIFT` = 4, load `t_a0` = 16384 (non-snap) → successive commits give a0 = 0, 1024, 1984, 2884, …; `settled` = 0 until a0 = 16384 exactly; other coefficients stay 0.
- **Negative / minimum step:** shadow b1 = 100, `t_b1` = 95 → b1 commits 99, 98, 97, 96, 95 (the ±1 rule applies), then `settled` = 1 with no overshoot. Also load `t_b2` = −32768 from 32767 → monotonic descent, no wrap.
- **Snap:** load all five with `load_snap` = 1 (a0 = 8192, a1 = −4096, a2 = 2048, b1 = −12000, b2 = 5000) → all five appear on the same edge at the next commit, `settled` = 1.
- **Handshake:** hold `load_valid` through a frame → `load_ready` low for exactly 5 cycles after each commit, exactly one transfer recorded per ready cycle, and the last value wins.
- **Short frame:** `lrclk` rises 3 cycles after a commit → no commit occurs; the following rise commits normally; outputs never change mid-UPD.
